rle_lane_packer: RTL and testbench

//  Parametrised run-length packer for the JPEG entropy path. Accepts quantised zig-zag

---
 rtl/rle_pkg.sv | 39 +++
 rtl/rle_out_reg.sv | 86 ++++++++
 rtl/rle_lane_packer.sv | 202 ++++++++++++++++++++
 tb/tb_rle_lane_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
//   Shared definitions for the run-length lane packer: FSM state encoding,
//   fixed symbol field values and constant-width helper functions.
// ---------------------------------------------------------------------------
package rle_pkg;

   // Packer sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for an input beat
      ST_SCAN = 2'd1,   // walking the latched beat one lane per cycle
      ST_EOB  = 2'd2    // emitting the end-of-block symbol
   } state_e;

   // EOB symbol is {run 0, coef 0} with the eob flag set.
   localparam int unsigned EOB_RUN  = 0;
   localparam int unsigned EOB_COEF = 0;

   // Ceiling log2, used to size counters from parameters.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

   // Clamp a computed width to at least one bit.
   function automatic int unsigned width_min1(input int unsigned w);
      return (w == 0) ? 32'd1 : w;
   endfunction

   // ZRL run value: all ones in the run field (15 for a 4-bit run).
   function automatic int unsigned zrl_run(input int unsigned run_w);
      return 32'((64'd1 << run_w) - 64'd1);
   endfunction

endpackage : rle_pkg

// File: rtl/rle_out_reg.sv
// ---------------------------------------------------------------------------
// rle_out_reg
//   One-entry output register for the packer symbol stream. Holds every
//   field stable while valid and not accepted; loads when empty or popped.
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   load_i           write a new symbol (only asserted when can_load_c_o)
//   run_i/coef_i     symbol fields to load
//   eob_i/blk_end_i  symbol flags to load
//   ready_i          downstream accepts the held symbol
//   can_load_c_o     combinational: register empty or being popped this cycle
//   valid_o, run_o, coef_o, eob_o, blk_end_o   registered symbol output
// ---------------------------------------------------------------------------
module rle_out_reg
   import rle_pkg::*;
#(
   parameter int unsigned RUN_W  = 4,
   parameter int unsigned COEF_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [RUN_W-1:0]  run_i,
   input  logic [COEF_W-1:0] coef_i,
   input  logic              eob_i,
   input  logic              blk_end_i,
   input  logic              ready_i,
   output logic              can_load_c_o,
   output logic              valid_o,
   output logic [RUN_W-1:0]  run_o,
   output logic [COEF_W-1:0] coef_o,
   output logic              eob_o,
   output logic              blk_end_o
);

   logic              valid_q,   valid_d;
   logic [RUN_W-1:0]  run_q,     run_d;
   logic [COEF_W-1:0] coef_q,    coef_d;
   logic              eob_q,     eob_d;
   logic              blk_end_q, blk_end_d;

   // Space is available when empty or when the held symbol leaves this cycle.
   assign can_load_c_o = !valid_q || ready_i;

   // Next-state: load wins, otherwise a pop empties the entry; fields hold.
   always_comb begin
      valid_d   = valid_q;
      run_d     = run_q;
      coef_d    = coef_q;
      eob_d     = eob_q;
      blk_end_d = blk_end_q;
      if (load_i) begin
         valid_d   = 1'b1;
         run_d     = run_i;
         coef_d    = coef_i;
         eob_d     = eob_i;
         blk_end_d = blk_end_i;
      end else if (ready_i) begin
         valid_d   = 1'b0;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         run_q     <= '0;
         coef_q    <= '0;
         eob_q     <= 1'b0;
         blk_end_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         run_q     <= run_d;
         coef_q    <= coef_d;
         eob_q     <= eob_d;
         blk_end_q <= blk_end_d;
      end
   end

   assign valid_o   = valid_q;
   assign run_o     = run_q;
   assign coef_o    = coef_q;
   assign eob_o     = eob_q;
   assign blk_end_o = blk_end_q;

endmodule : rle_out_reg

// File: rtl/rle_lane_packer.sv
// ---------------------------------------------------------------------------
// rle_lane_packer
//   Run-length packer for the JPEG entropy path. Accepts LANES zig-zag
//   coefficients per beat and emits one {run,coef} symbol per cycle, with
//   ZRL (15/0) and EOB (0/0) insertion, optional DC bypass, back-pressure
//   and block-boundary marking.
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   in_valid       input beat valid
//   in_ready       packer idle and able to take a beat (registered)
//   in_data        LANES coefficients, lane 0 in the most significant slot
//   out_valid      symbol valid
//   out_ready      downstream accepts symbol
//   out_run        zeros preceding out_coef
//   out_coef       coefficient value (0 for ZRL/EOB)
//   out_eob        symbol is EOB
//   out_blk_end    last symbol of the current block
// ---------------------------------------------------------------------------
module rle_lane_packer
   import rle_pkg::*;
#(
   parameter int unsigned LANES     = 8,
   parameter int unsigned COEF_W    = 8,
   parameter int unsigned RUN_W     = 4,
   parameter int unsigned BLOCK_LEN = 64,
   parameter int unsigned DC_BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*COEF_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RUN_W-1:0]        out_run,
   output logic [COEF_W-1:0]       out_coef,
   output logic                    out_eob,
   output logic                    out_blk_end
);

   localparam int unsigned DATA_W  = LANES * COEF_W;
   localparam int unsigned LANE_W  = width_min1(clog2(LANES));
   localparam int unsigned IDX_W   = width_min1(clog2(BLOCK_LEN));
   // One extra bit so a fully zero block (BLOCK_LEN zeros) is representable.
   localparam int unsigned ZR_W    = clog2(BLOCK_LEN) + 1;
   localparam int unsigned ZRL_RUN = zrl_run(RUN_W);

   state_e              state_q,    state_d;
   logic [LANE_W-1:0]   lane_q,     lane_d;
   logic [IDX_W-1:0]    coef_idx_q, coef_idx_d;
   logic [ZR_W-1:0]     zero_run_q, zero_run_d;
   logic [DATA_W-1:0]   data_q,     data_d;
   logic                in_ready_q, in_ready_d;

   logic [COEF_W-1:0]   cur_coef_c;
   logic                last_idx_c;
   logic                dc_lane_c;
   logic                advance_c;
   logic                can_emit_c;
   logic                load_c;
   logic [RUN_W-1:0]    ld_run_c;
   logic [COEF_W-1:0]   ld_coef_c;
   logic                ld_eob_c;
   logic                ld_blk_end_c;

   // Lane mux: lane 0 sits in the most significant coefficient slot.
   always_comb begin
      cur_coef_c = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (lane_q == LANE_W'(k)) cur_coef_c = data_q[(LANES-k)*COEF_W-1 -: COEF_W];
      end
   end

   assign last_idx_c = (coef_idx_q == IDX_W'(BLOCK_LEN - 1));
   assign dc_lane_c  = (DC_BYPASS != 0) && (coef_idx_q == '0);

   // Next-state, counters and symbol generation.
   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      coef_idx_d   = coef_idx_q;
      zero_run_d   = zero_run_q;
      data_d       = data_q;
      advance_c    = 1'b0;
      load_c       = 1'b0;
      ld_run_c     = '0;
      ld_coef_c    = '0;
      ld_eob_c     = 1'b0;
      ld_blk_end_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               data_d  = in_data;
               lane_d  = '0;
               state_d = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (dc_lane_c) begin
               // DC always goes out as run 0, even when zero.
               if (can_emit_c) begin
                  load_c    = 1'b1;
                  ld_coef_c = cur_coef_c;
                  advance_c = 1'b1;
               end
            end else if (cur_coef_c == '0) begin
               // Zeros only count; they never wait on the output register.
               zero_run_d = zero_run_q + ZR_W'(1);
               advance_c  = 1'b1;
            end else if (zero_run_q > ZR_W'(ZRL_RUN)) begin
               // Run too long for one symbol: ZRL and stay on this lane.
               if (can_emit_c) begin
                  load_c     = 1'b1;
                  ld_run_c   = RUN_W'(ZRL_RUN);
                  zero_run_d = zero_run_q - ZR_W'(ZRL_RUN + 1);
               end
            end else begin
               if (can_emit_c) begin
                  load_c       = 1'b1;
                  ld_run_c     = RUN_W'(zero_run_q);
                  ld_coef_c    = cur_coef_c;
                  ld_blk_end_c = last_idx_c;
                  zero_run_d   = '0;
                  advance_c    = 1'b1;
               end
            end

            if (advance_c) begin
               coef_idx_d = last_idx_c ? '0 : coef_idx_q + IDX_W'(1);
               if (lane_q == LANE_W'(LANES - 1)) begin
                  // Trailing zeros at block end collapse into one EOB.
                  state_d = (last_idx_c && (zero_run_d != '0)) ? ST_EOB : ST_IDLE;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
         end

         ST_EOB: begin
            if (can_emit_c) begin
               load_c       = 1'b1;
               ld_run_c     = RUN_W'(EOB_RUN);
               ld_coef_c    = COEF_W'(EOB_COEF);
               ld_eob_c     = 1'b1;
               ld_blk_end_c = 1'b1;
               zero_run_d   = '0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lane_q     <= '0;
         coef_idx_q <= '0;
         zero_run_q <= '0;
         data_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         coef_idx_q <= coef_idx_d;
         zero_run_q <= zero_run_d;
         data_q     <= data_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;

   rle_out_reg #(
      .RUN_W  (RUN_W),
      .COEF_W (COEF_W)
   ) u_out_reg (
      .clk          (clk),
      .reset        (reset),
      .load_i       (load_c),
      .run_i        (ld_run_c),
      .coef_i       (ld_coef_c),
      .eob_i        (ld_eob_c),
      .blk_end_i    (ld_blk_end_c),
      .ready_i      (out_ready),
      .can_load_c_o (can_emit_c),
      .valid_o      (out_valid),
      .run_o        (out_run),
      .coef_o       (out_coef),
      .eob_o        (out_eob),
      .blk_end_o    (out_blk_end)
   );

endmodule : rle_lane_packer

// File: tb/tb_rle_lane_packer.sv
// ---------------------------------------------------------------------------
// tb_rle_lane_packer
//   Directed bench for rle_lane_packer: dut_a with DC bypass, dut_b without.
//   Block vectors with hand-computed symbol streams are applied from a table.
// ---------------------------------------------------------------------------
module tb_rle_lane_packer;

   localparam int unsigned LANES     = 8;
   localparam int unsigned COEF_W    = 8;
   localparam int unsigned RUN_W     = 4;
   localparam int unsigned BLOCK_LEN = 64;

   typedef struct packed {
      logic [3:0] run;
      logic [7:0] coef;
      logic       eob;
      logic       blk_end;
   } sym_t;

   typedef struct {
      int           sel;     // 0: dut_a (DC bypass), 1: dut_b
      int           rmode;   // 0: always ready, 1: ready 1-of-3, 2: never
      logic [511:0] blk;     // coefficient i at [i*8 +: 8]
      int           n_exp;
      sym_t [63:0]  exp_s;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = '0;
   logic        out_ready = 1'b1;
   int          rmode = 0;
   int          tog_cyc = 0;

   logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_eob_a, out_blk_end_a;
   logic [3:0]  out_run_a;
   logic [7:0]  out_coef_a;
   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_eob_b, out_blk_end_b;
   logic [3:0]  out_run_b;
   logic [7:0]  out_coef_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   sym_t q_a[$];
   sym_t q_b[$];
   vec_t vecs[12];
   int   nvec = 0;
   vec_t tv;

   sym_t cur_a, cur_b, held_a, held_b;
   logic held_v_a = 1'b0, held_v_b = 1'b0;

   rle_lane_packer #(.LANES(LANES), .COEF_W(COEF_W), .RUN_W(RUN_W),
                     .BLOCK_LEN(BLOCK_LEN), .DC_BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_run(out_run_a), .out_coef(out_coef_a), .out_eob(out_eob_a),
      .out_blk_end(out_blk_end_a));

   rle_lane_packer #(.LANES(LANES), .COEF_W(COEF_W), .RUN_W(RUN_W),
                     .BLOCK_LEN(BLOCK_LEN), .DC_BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_run(out_run_b), .out_coef(out_coef_b), .out_eob(out_eob_b),
      .out_blk_end(out_blk_end_b));

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream ready pattern, changed just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      tog_cyc++;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((tog_cyc % 3) == 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Output monitors: collect accepted symbols, check fields hold while stalled.
   always @(negedge clk) begin
      cur_a = {out_run_a, out_coef_a, out_eob_a, out_blk_end_a};
      if (reset) held_v_a = 1'b0;
      else begin
         if (held_v_a) chk("stall_hold_a", 32'({out_valid_a, cur_a}), 32'({1'b1, held_a}));
         if (out_valid_a && out_ready) q_a.push_back(cur_a);
         held_v_a = out_valid_a && !out_ready;
         held_a   = cur_a;
      end
   end

   always @(negedge clk) begin
      cur_b = {out_run_b, out_coef_b, out_eob_b, out_blk_end_b};
      if (reset) held_v_b = 1'b0;
      else begin
         if (held_v_b) chk("stall_hold_b", 32'({out_valid_b, cur_b}), 32'({1'b1, held_b}));
         if (out_valid_b && out_ready) q_b.push_back(cur_b);
         held_v_b = out_valid_b && !out_ready;
         held_b   = cur_b;
      end
   end

   function automatic logic rdy(input int sel);
      return (sel == 1) ? in_ready_b : in_ready_a;
   endfunction

   function automatic logic ovld(input int sel);
      return (sel == 1) ? out_valid_b : out_valid_a;
   endfunction

   task automatic drive_valid(input int sel, input logic v);
      if (sel == 1) in_valid_b = v;
      else          in_valid_a = v;
   endtask

   // Present a beat and return just after the edge that accepted it.
   task automatic accept_beat(input int sel, input logic [63:0] beat, input string tag);
      bit acc;
      acc = 1'b0;
      in_data = beat;
      drive_valid(sel, 1'b1);
      for (int i = 0; i < 400; i++) begin
         if (rdy(sel)) begin
            @(posedge clk);
            #1;
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      drive_valid(sel, 1'b0);
      chk({tag, " accept"}, 32'(acc), 32'd1);
   endtask

   // Accept a beat, then require in_ready to stay low for at least LANES cycles.
   task automatic send_beat(input int sel, input logic [63:0] beat, input string tag);
      int busy;
      bit done;
      accept_beat(sel, beat, tag);
      busy = 0;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rdy(sel)) begin
            done = 1'b1;
            break;
         end
         busy++;
      end
      chk({tag, " busy_end"}, 32'(done), 32'd1);
      chk({tag, " busy_min"}, 32'(busy >= int'(LANES)), 32'd1);
   endtask

   task automatic wait_drain(input int sel, input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (rdy(sel) && !ovld(sel)) begin
            done = 1'b1;
            break;
         end
      end
      chk({tag, " drain"}, 32'(done), 32'd1);
   endtask

   task automatic new_vec(input int sel, input int rm);
      tv.sel   = sel;
      tv.rmode = rm;
      tv.blk   = '0;
      tv.n_exp = 0;
      tv.exp_s = '0;
   endtask

   task automatic put(input int idx, input logic [7:0] val);
      tv.blk[idx*8 +: 8] = val;
   endtask

   task automatic es(input logic [3:0] run, input logic [7:0] coef, input logic eob, input logic be);
      tv.exp_s[tv.n_exp] = {run, coef, eob, be};
      tv.n_exp++;
   endtask

   task automatic commit();
      vecs[nvec] = tv;
      nvec++;
   endtask

   initial begin
      logic [63:0] beat;
      sym_t        got[$];
      string       tag;

      // ---------------- vector table ----------------
      // v0: DC 5, 19 zeros, 7 at idx20 -> DC, ZRL, {3,7}, EOB
      new_vec(0, 0); put(0, 8'd5); put(20, 8'd7);
      es(4'd0, 8'd5, 0, 0); es(4'd15, 8'd0, 0, 0); es(4'd3, 8'd7, 0, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v1: 52,0,0,3,-1,0..0
      new_vec(0, 0); put(0, 8'd52); put(3, 8'd3); put(4, 8'hFF);
      es(4'd0, 8'd52, 0, 0); es(4'd2, 8'd3, 0, 0); es(4'd0, 8'hFF, 0, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v2: all nonzero ramp, no EOB, blk_end on idx 63
      new_vec(0, 0);
      for (int i = 0; i < 64; i++) begin
         put(i, 8'(i + 1));
         es(4'd0, 8'(i + 1), 1'b0, 1'(i == 63));
      end
      commit();
      // v3: v1 under back-pressure
      new_vec(0, 1); put(0, 8'd52); put(3, 8'd3); put(4, 8'hFF);
      es(4'd0, 8'd52, 0, 0); es(4'd2, 8'd3, 0, 0); es(4'd0, 8'hFF, 0, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v4: zero DC still emitted; 62 zeros -> 3 ZRL then {14,-5} closing the block
      new_vec(0, 0); put(63, 8'hFB);
      es(4'd0, 8'd0, 0, 0); es(4'd15, 8'd0, 0, 0); es(4'd15, 8'd0, 0, 0); es(4'd15, 8'd0, 0, 0);
      es(4'd14, 8'hFB, 0, 1); commit();
      // v5: run of exactly 15 fits without ZRL
      new_vec(0, 0); put(0, 8'd1); put(16, 8'd2);
      es(4'd0, 8'd1, 0, 0); es(4'd15, 8'd2, 0, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v6, v7: no DC bypass, all-zero block twice -> single EOB each
      new_vec(1, 0); es(4'd0, 8'd0, 1, 1); commit();
      new_vec(1, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v8: no DC bypass, run of 16 -> ZRL then {0,4}
      new_vec(1, 0); put(16, 8'd4);
      es(4'd15, 8'd0, 0, 0); es(4'd0, 8'd4, 0, 0); es(4'd0, 8'd0, 1, 1); commit();
      // v9: no DC bypass, negative idx0, nonzero last under back-pressure
      new_vec(1, 1); put(0, 8'hFD); put(63, 8'd1);
      es(4'd0, 8'hFD, 0, 0); es(4'd15, 8'd0, 0, 0); es(4'd15, 8'd0, 0, 0); es(4'd15, 8'd0, 0, 0);
      es(4'd14, 8'd1, 0, 1); commit();

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk("rst in_ready_a", 32'(in_ready_a), 32'd0);
      chk("rst out_valid_a", 32'(out_valid_a), 32'd0);
      chk("rst out_run_a", 32'(out_run_a), 32'd0);
      chk("rst out_coef_a", 32'(out_coef_a), 32'd0);
      chk("rst out_eob_a", 32'(out_eob_a), 32'd0);
      chk("rst out_blk_end_a", 32'(out_blk_end_a), 32'd0);
      chk("rst in_ready_b", 32'(in_ready_b), 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("post_rst in_ready_a", 32'(in_ready_a), 32'd1);

      // ---------------- reset mid-SCAN with a stalled symbol ----------------
      rmode = 2;
      @(posedge clk); @(negedge clk);
      accept_beat(0, {8'd52, 8'd0, 8'd0, 8'd3, 8'hFF, 8'd0, 8'd0, 8'd0}, "midrst");
      repeat (4) @(negedge clk);
      chk("midrst out_valid", 32'(out_valid_a), 32'd1);
      chk("midrst dc_sym", 32'({out_run_a, out_coef_a, out_eob_a}), 32'({4'd0, 8'd52, 1'b0}));
      chk("midrst in_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst rst out_valid", 32'(out_valid_a), 32'd0);
      chk("midrst rst in_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      rmode = 0;
      @(posedge clk); @(negedge clk);
      chk("midrst after in_ready", 32'(in_ready_a), 32'd1);
      chk("midrst after out_valid", 32'(out_valid_a), 32'd0);

      // ---------------- table-driven blocks ----------------
      for (int v = 0; v < nvec; v++) begin
         q_a.delete();
         q_b.delete();
         rmode = vecs[v].rmode;
         for (int b = 0; b < int'(BLOCK_LEN / LANES); b++) begin
            for (int k = 0; k < int'(LANES); k++)
               beat[(LANES-k)*COEF_W-1 -: COEF_W] = vecs[v].blk[(b*LANES+k)*COEF_W +: COEF_W];
            tag = $sformatf("v%0d beat%0d", v, b);
            send_beat(vecs[v].sel, beat, tag);
         end
         wait_drain(vecs[v].sel, $sformatf("v%0d", v));
         repeat (2) @(negedge clk);
         if (vecs[v].sel == 1) got = q_b;
         else                  got = q_a;
         chk($sformatf("v%0d sym_count", v), 32'(got.size()), 32'(vecs[v].n_exp));
         for (int j = 0; j < vecs[v].n_exp && j < got.size(); j++)
            chk($sformatf("v%0d sym%0d {run,coef,eob,blk_end}", v, j),
                32'(got[j]), 32'(vecs[v].exp_s[j]));
      end

      rmode = 0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_rle_lane_packer
